// File: rtl/axilite_noc_pkg.sv
// Shared message codes, P-Mesh header field positions and FSM state types for the
// AXI-Lite <-> NoC request/response bridge.
package axilite_noc_pkg;

    localparam int unsigned NOC_DATA_WIDTH = 64;

    // Transaction-type records exchanged with the response block
    localparam logic [1:0] MSG_TYPE_INVAL = 2'd0;
    localparam logic [1:0] MSG_TYPE_LOAD  = 2'd1;
    localparam logic [1:0] MSG_TYPE_STORE = 2'd2;

    // P-Mesh message types and header field positions, mirroring the define.tmp.h layout
    localparam logic [7:0] MSG_TYPE_NC_LOAD_REQ  = 8'd14;
    localparam logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd15;

    localparam int unsigned MSG_DST_CHIPID_HI = 63;
    localparam int unsigned MSG_DST_CHIPID_LO = 50;
    localparam int unsigned MSG_DST_X_HI      = 49;
    localparam int unsigned MSG_DST_X_LO      = 42;
    localparam int unsigned MSG_DST_Y_HI      = 41;
    localparam int unsigned MSG_DST_Y_LO      = 34;
    localparam int unsigned MSG_LENGTH_HI     = 29;
    localparam int unsigned MSG_LENGTH_LO     = 22;
    localparam int unsigned MSG_TYPE_HI       = 21;
    localparam int unsigned MSG_TYPE_LO       = 14;
    localparam int unsigned MSG_MSHRID_HI     = 13;
    localparam int unsigned MSG_MSHRID_LO     = 6;
    localparam int unsigned MSG_ADDR_HI       = 63;
    localparam int unsigned MSG_ADDR_LO       = 24;
    localparam int unsigned MSG_ADDR_WIDTH    = 40;
    localparam int unsigned MSG_DATA_SIZE_HI  = 22;
    localparam int unsigned MSG_DATA_SIZE_LO  = 20;
    localparam int unsigned MSG_SRC_CHIPID_HI = 63;
    localparam int unsigned MSG_SRC_CHIPID_LO = 50;
    localparam int unsigned MSG_SRC_X_HI      = 49;
    localparam int unsigned MSG_SRC_X_LO      = 42;
    localparam int unsigned MSG_SRC_Y_HI      = 41;
    localparam int unsigned MSG_SRC_Y_LO      = 34;

    typedef enum logic [2:0] {ReqIdle, ReqHdr0, ReqHdr1, ReqHdr2, ReqData} req_state_e;
    typedef enum logic [1:0] {RespIdle, RespHdr, RespData} resp_state_e;

    // Size code: 0 = 0 B, 1 = 1 B, ... so n bytes encodes as log2(n) + 1
    function automatic logic [2:0] data_size_enc(input int unsigned bytes);
        return 3'($clog2(bytes) + 1);
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[56-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_flit_serializer.sv
// Holds a wide store payload and hands it out one byte-swapped 64-bit flit at a time.
module noc_flit_serializer
    import axilite_noc_pkg::*;
#(
    parameter int unsigned NumFlits = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_i,
    input  logic [NumFlits*NOC_DATA_WIDTH-1:0]  data_i,
    input  logic                                clear_i,
    input  logic                                advance_i,
    output logic [NOC_DATA_WIDTH-1:0]           flit_o,
    output logic                                done_o
);
    localparam int unsigned CntW = $clog2(NumFlits) + 1;

    logic [NumFlits*NOC_DATA_WIDTH-1:0] data_q, data_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;

    always_comb begin
        data_d = load_i ? data_i : data_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q is the index of the next flit to hand out; NumFlits means all handed out
    always_comb begin
        flit_o = '0;
        for (int unsigned k = 0; k < NumFlits; k++) begin
            if (cnt_q == CntW'(k)) begin
                flit_o = bswap64(data_q[k*NOC_DATA_WIDTH +: NOC_DATA_WIDTH]);
            end
        end
    end

    assign done_o = (cnt_q == CntW'(NumFlits));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/axilite_noc_request.sv
// AXI-Lite slave to P-Mesh NoC1 request packetizer: one AR or AW+W becomes one NoC message,
// and a type record is pushed so the response side knows what comes back.
module axilite_noc_request
    import axilite_noc_pkg::*;
#(
    parameter int unsigned AXI_LITE_ADDR_WIDTH = 64,
    parameter int unsigned AXI_LITE_DATA_WIDTH = 512,
    parameter int unsigned MSHRID              = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    input  logic [13:0]                    src_chipid,
    input  logic [7:0]                     src_x,
    input  logic [7:0]                     src_y,
    input  logic [13:0]                    dst_chipid,
    input  logic [7:0]                     dst_x,
    input  logic [7:0]                     dst_y,
    output logic                           noc_valid_out,
    output logic [NOC_DATA_WIDTH-1:0]      noc_data_out,
    input  logic                           noc_ready_in,
    output logic                           type_wr,
    output logic [2:0]                     type_wr_data,
    input  logic                           type_fifo_full
);
    localparam int unsigned NumFlits = AXI_LITE_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam logic [7:0]  LoadLen  = 8'd2;
    localparam logic [7:0]  StoreLen = 8'(2 + NumFlits);
    localparam logic [2:0]  DataSize = data_size_enc(AXI_LITE_DATA_WIDTH / 8);

    req_state_e                  state_q, state_d;
    logic                        rr_last_q, rr_last_d;  // 1: last accepted request was a write
    logic                        is_store_q, is_store_d;
    logic [MSG_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                        noc_valid_q, noc_valid_d;
    logic [NOC_DATA_WIDTH-1:0]   noc_data_q, noc_data_d;

    logic rd_elig, wr_elig, take_rd, take_wr, accept, flit_hs;
    logic ser_advance, ser_done;
    logic [NOC_DATA_WIDTH-1:0] ser_flit, hdr0, hdr1, hdr2;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

    always_comb begin
        rd_elig = (state_q == ReqIdle) && s_axi_arvalid && !type_fifo_full;
        wr_elig = (state_q == ReqIdle) && s_axi_awvalid && s_axi_wvalid && !type_fifo_full;
        take_rd = rd_elig && (!wr_elig || rr_last_q);
        take_wr = wr_elig && !take_rd;
        accept  = take_rd || take_wr;
        flit_hs = noc_valid_q && noc_ready_in;
    end

    assign s_axi_arready = take_rd;
    assign s_axi_awready = take_wr;
    assign s_axi_wready  = take_wr;
    assign type_wr       = accept;
    assign type_wr_data  = accept ? {(take_wr ? MSG_TYPE_STORE : MSG_TYPE_LOAD), 1'b0} : 3'b000;
    assign noc_valid_out = noc_valid_q;
    assign noc_data_out  = noc_data_q;

    // hdr0 is only loaded on accept, so it keys off the current selection
    always_comb begin
        hdr0 = '0;
        hdr0[MSG_DST_CHIPID_HI:MSG_DST_CHIPID_LO] = dst_chipid;
        hdr0[MSG_DST_X_HI:MSG_DST_X_LO]           = dst_x;
        hdr0[MSG_DST_Y_HI:MSG_DST_Y_LO]           = dst_y;
        hdr0[MSG_LENGTH_HI:MSG_LENGTH_LO]         = take_wr ? StoreLen : LoadLen;
        hdr0[MSG_TYPE_HI:MSG_TYPE_LO] = take_wr ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ;
        hdr0[MSG_MSHRID_HI:MSG_MSHRID_LO]         = 8'(MSHRID);
        hdr1 = '0;
        hdr1[MSG_ADDR_HI:MSG_ADDR_LO]             = addr_q;
        hdr1[MSG_DATA_SIZE_HI:MSG_DATA_SIZE_LO]   = DataSize;
        hdr2 = '0;
        hdr2[MSG_SRC_CHIPID_HI:MSG_SRC_CHIPID_LO] = src_chipid;
        hdr2[MSG_SRC_X_HI:MSG_SRC_X_LO]           = src_x;
        hdr2[MSG_SRC_Y_HI:MSG_SRC_Y_LO]           = src_y;
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        noc_valid_d = noc_valid_q;
        noc_data_d  = noc_data_q;
        ser_advance = 1'b0;
        unique case (state_q)
            ReqIdle: begin
                if (accept) begin
                    state_d     = ReqHdr0;
                    rr_last_d   = take_wr;
                    is_store_d  = take_wr;
                    addr_d      = take_wr ? s_axi_awaddr[MSG_ADDR_WIDTH-1:0]
                                          : s_axi_araddr[MSG_ADDR_WIDTH-1:0];
                    noc_valid_d = 1'b1;
                    noc_data_d  = hdr0;
                end
            end
            ReqHdr0: begin
                if (flit_hs) begin
                    state_d    = ReqHdr1;
                    noc_data_d = hdr1;
                end
            end
            ReqHdr1: begin
                if (flit_hs) begin
                    state_d    = ReqHdr2;
                    noc_data_d = hdr2;
                end
            end
            ReqHdr2: begin
                if (flit_hs) begin
                    if (is_store_q) begin
                        state_d     = ReqData;
                        noc_data_d  = ser_flit;
                        ser_advance = 1'b1;
                    end else begin
                        state_d     = ReqIdle;
                        noc_valid_d = 1'b0;
                        noc_data_d  = '0;
                    end
                end
            end
            ReqData: begin
                if (flit_hs) begin
                    if (ser_done) begin
                        state_d     = ReqIdle;
                        noc_valid_d = 1'b0;
                        noc_data_d  = '0;
                    end else begin
                        noc_data_d  = ser_flit;
                        ser_advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ReqIdle;
                noc_valid_d = 1'b0;
                noc_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ReqIdle;
            rr_last_q   <= 1'b1;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            noc_valid_q <= 1'b0;
            noc_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            noc_valid_q <= noc_valid_d;
            noc_data_q  <= noc_data_d;
        end
    end

    noc_flit_serializer #(
        .NumFlits (NumFlits)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (take_wr),
        .data_i    (s_axi_wdata),
        .clear_i   (accept),
        .advance_i (ser_advance),
        .flit_o    (ser_flit),
        .done_o    (ser_done)
    );

endmodule

// File: tb/tb_axilite_noc_request.sv
// Bench for axilite_noc_request: directed requests, a queue-based message model checked
// every cycle, and literal flit values for the key scenarios.
module tb_axilite_noc_request;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 512;
    localparam int unsigned NF = DW / 64;
    localparam logic [13:0] DST_CHIP = 14'h0005;
    localparam logic [7:0]  DST_X    = 8'h01;
    localparam logic [7:0]  DST_Y    = 8'h02;
    localparam logic [13:0] SRC_CHIP = 14'h0003;
    localparam logic [7:0]  SRC_X    = 8'h03;
    localparam logic [7:0]  SRC_Y    = 8'h04;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] s_axi_araddr, s_axi_awaddr;
    logic          s_axi_arvalid, s_axi_awvalid, s_axi_wvalid;
    logic          s_axi_arready, s_axi_awready, s_axi_wready;
    logic [DW-1:0] s_axi_wdata;
    logic          noc_valid_out, noc_ready_in, type_wr, type_fifo_full;
    logic [63:0]   noc_data_out;
    logic [2:0]    type_wr_data;

    always #5 clk = ~clk;

    axilite_noc_request #(
        .AXI_LITE_ADDR_WIDTH (AW),
        .AXI_LITE_DATA_WIDTH (DW),
        .MSHRID              (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .src_chipid     (SRC_CHIP),
        .src_x          (SRC_X),
        .src_y          (SRC_Y),
        .dst_chipid     (DST_CHIP),
        .dst_x          (DST_X),
        .dst_y          (DST_Y),
        .noc_valid_out  (noc_valid_out),
        .noc_data_out   (noc_data_out),
        .noc_ready_in   (noc_ready_in),
        .type_wr        (type_wr),
        .type_wr_data   (type_wr_data),
        .type_fifo_full (type_fifo_full)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];
    bit          m_rr_last = 1'b1;  // 1: write was accepted last
    logic [63:0] seen[64];
    int          seen_n = 0;
    int          acc[16];
    int          acc_cyc[16];
    int          acc_n = 0;
    logic [2:0]  last_type = 3'b000;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] m_hdr0(input bit st);
        int unsigned len = st ? 2 + NF : 2;
        int unsigned typ = st ? 15 : 14;
        return (64'(DST_CHIP) << 50) | (64'(DST_X) << 42) | (64'(DST_Y) << 34)
             | (64'(len) << 22) | (64'(typ) << 14);
    endfunction

    function automatic logic [63:0] m_hdr1(input logic [AW-1:0] a);
        logic [39:0] a40 = a[39:0];
        return (64'(a40) << 24) | (64'(7) << 20);
    endfunction

    function automatic logic [63:0] m_hdr2();
        return (64'(SRC_CHIP) << 50) | (64'(SRC_X) << 42) | (64'(SRC_Y) << 34);
    endfunction

    // Flit k carries payload bytes 8k..8k+7, lowest-addressed byte in the top lane
    function automatic logic [63:0] m_data(input logic [DW-1:0] wd, input int k);
        logic [63:0] f;
        for (int b = 0; b < 8; b++) f[63-8*b -: 8] = wd[(k*8+b)*8 +: 8];
        return f;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit busy, rd_e, wr_e, e_rd, e_wr;
        if (!rst_n) begin
            check_eq("reset_ctrl", 64'({noc_valid_out, s_axi_arready, s_axi_awready,
                                        s_axi_wready, type_wr}), 64'd0);
            check_eq("reset_data", noc_data_out, 64'd0);
            exp_q.delete();
            m_rr_last  = 1'b1;
            prev_stall = 1'b0;
        end else begin
            busy = exp_q.size() != 0;
            rd_e = !busy && s_axi_arvalid && !type_fifo_full;
            wr_e = !busy && s_axi_awvalid && s_axi_wvalid && !type_fifo_full;
            e_rd = rd_e && (!wr_e || m_rr_last);
            e_wr = wr_e && !e_rd;
            check_eq("arready", 64'(s_axi_arready), 64'(e_rd));
            check_eq("awready", 64'(s_axi_awready), 64'(e_wr));
            check_eq("wready", 64'(s_axi_wready), 64'(e_wr));
            check_eq("type_wr", 64'(type_wr), 64'(e_rd || e_wr));
            check_eq("noc_valid", 64'(noc_valid_out), 64'(busy));
            if (busy) check_eq("noc_data", noc_data_out, exp_q[0]);
            if (prev_stall) check_eq("stall_hold", noc_data_out, prev_data);
            prev_stall = busy && !noc_ready_in;
            prev_data  = noc_data_out;
            if (busy && noc_ready_in) begin
                if (seen_n < 64) seen[seen_n] = noc_data_out;
                seen_n++;
                void'(exp_q.pop_front());
            end
            if (e_rd || e_wr) begin
                check_eq("type_data", 64'(type_wr_data), e_wr ? 64'd4 : 64'd2);
                last_type = type_wr_data;
                if (acc_n < 16) begin
                    acc[acc_n]     = e_wr ? 1 : 0;
                    acc_cyc[acc_n] = cyc;
                end
                acc_n++;
                exp_q.push_back(m_hdr0(e_wr));
                exp_q.push_back(m_hdr1(e_wr ? s_axi_awaddr : s_axi_araddr));
                exp_q.push_back(m_hdr2());
                if (e_wr) for (int k = 0; k < int'(NF); k++) exp_q.push_back(m_data(s_axi_wdata, k));
                m_rr_last = e_wr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_n < target && n < 200) begin
            step();
            n++;
        end
        check_eq("accept_count", 64'(acc_n), 64'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_axi_araddr = '0; s_axi_awaddr = '0; s_axi_wdata = '0;
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        noc_ready_in = 1'b1; type_fifo_full = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single load, arvalid held for a second back-to-back load
        seen_n = 0; acc_n = 0;
        s_axi_araddr = 64'h8000_1000; s_axi_arvalid = 1'b1;
        wait_acc(2);
        s_axi_arvalid = 1'b0;
        wait_idle();
        check_eq("ld_count", 64'(seen_n), 64'd6);
        check_eq("ld_hdr0", seen[0], 64'h0014_0408_0083_8000);
        check_eq("ld_hdr1", seen[1], 64'h0080_0010_0070_0000);
        check_eq("ld_hdr2", seen[2], 64'h000C_0C10_0000_0000);
        check_eq("ld_type", 64'(last_type), 64'd2);
        check_eq("ld_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);

        // Single store, payload bytes 0x00..0x3F
        seen_n = 0; acc_n = 0;
        for (int i = 0; i < 64; i++) s_axi_wdata[i*8 +: 8] = 8'(i);
        s_axi_awaddr = 64'h8000_2000; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        wait_acc(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_idle();
        check_eq("st_count", 64'(seen_n), 64'd11);
        check_eq("st_hdr0", seen[0], 64'h0014_0408_0283_C000);
        check_eq("st_hdr1", seen[1], 64'h0080_0020_0070_0000);
        check_eq("st_data0", seen[3], 64'h0001_0203_0405_0607);
        check_eq("st_data7", seen[10], 64'h3839_3A3B_3C3D_3E3F);
        check_eq("st_type", 64'(last_type), 64'd4);

        // Read and write competing: served alternately starting with the read
        acc_n = 0;
        s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        wait_acc(4);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_idle();
        check_eq("rr_0", 64'(acc[0]), 64'd0);
        check_eq("rr_1", 64'(acc[1]), 64'd1);
        check_eq("rr_2", 64'(acc[2]), 64'd0);
        check_eq("rr_3", 64'(acc[3]), 64'd1);

        // AW without W is not eligible
        s_axi_awaddr = 64'h8000_4000; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("aw_only_ready", 64'(s_axi_awready), 64'd0);
            check_eq("aw_only_valid", 64'(noc_valid_out), 64'd0);
        end
        step();
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        check_eq("aw_w_ready", 64'({s_axi_awready, s_axi_wready}), 64'd3);
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_idle();

        // Store under random backpressure
        seen_n = 0; acc_n = 0;
        for (int i = 0; i < 64; i++) s_axi_wdata[i*8 +: 8] = 8'(8'hA0 + i);
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; noc_ready_in = 1'b0;
        wait_acc(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_wdata = '1;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            noc_ready_in = 1'($urandom_range(0, 1));
            step();
        end
        noc_ready_in = 1'b1;
        wait_idle();
        check_eq("bp_count", 64'(seen_n), 64'd11);
        check_eq("bp_data0", seen[3], 64'hA0A1_A2A3_A4A5_A6A7);
        check_eq("bp_data7", seen[10], 64'hD8D9_DADB_DCDD_DEDF);

        // Type FIFO full blocks acceptance
        s_axi_araddr = 64'h8000_5000; s_axi_arvalid = 1'b1; type_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("full_block", 64'(s_axi_arready), 64'd0);
        end
        step();
        type_fifo_full = 1'b0;
        @(negedge clk);
        check_eq("full_release", 64'(s_axi_arready), 64'd1);
        step();
        s_axi_arvalid = 1'b0;
        wait_idle();

        // Reset in the middle of a store, then a clean load
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        acc_n = 0;
        wait_acc(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 64'(noc_valid_out), 64'd0);
        check_eq("mid_rst_data", noc_data_out, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        seen_n = 0;
        s_axi_araddr = 64'h8000_3000; s_axi_arvalid = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(s_axi_arready), 64'd1);
        step();
        s_axi_arvalid = 1'b0;
        wait_idle();
        check_eq("post_rst_count", 64'(seen_n), 64'd3);
        check_eq("post_rst_hdr1", seen[1], 64'h0080_0030_0070_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
